fifo_stream_reader: RTL and testbench

//   Read-side master for Synchronous_FIFO: drives its r_enb, captures its registered d_out
//   (valid 1 cycle after an accepted read) and re-presents the data as a valid/ready stream.
//   A 2-entry skid buffer sustains 1 beat/clk under back-pressure. The block also frames

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_stream_reader_if.sv | 37 +++
 rtl/fifo_stream_reader_skid.sv | 51 +++++
 rtl/fifo_stream_reader.sv | 88 ++++++++
 tb/tb_fifo_stream_reader.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 32;

    typedef logic [FIFO_WIDTH_DEFAULT-1:0] fifo_word_t;

    // Counter width for n states, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus the outgoing valid/ready stream, seen from the reader (master)
// and from the FIFO/consumer side (slave).
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEFAULT
);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_d_out;
    logic             fifo_r_enb;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        input  fifo_empty,
        input  fifo_d_out,
        output fifo_r_enb,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_d_out,
        input  fifo_r_enb,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_last
    );

endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry in-order shift buffer. slot0 is always the head; a pop shifts slot1 down
// and a push lands in the first free slot after any same-cycle pop.
module stream_skid_buf2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [1:0]       wr_slot;

    // Slot index for an incoming word once this cycle's pop has been accounted for.
    assign wr_slot = occ - {1'b0, pop};
    assign head    = slot0;

    // Occupancy tracks pushes minus pops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ <= 2'd0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Shift on pop, then write the captured word into the tail slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop) begin
                slot0 <= slot1;
            end
            if (push) begin
                if (wr_slot == 2'd0) begin
                    slot0 <= push_data;
                end else if (wr_slot == 2'd1) begin
                    slot1 <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a synchronous FIFO with registered read data. Issues reads only
// when the word can be guaranteed a buffer slot on arrival, re-presents the data as a
// valid/ready stream and frames it into bursts of BURST_LEN beats.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH_DEFAULT,
    parameter int BURST_LEN = 16,
    parameter int PKT_CW    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    fifo_stream_reader_if.master bus,
    output logic [PKT_CW-1:0] pkt_count,
    output logic              idle
);

    localparam int            BW        = clog2_min1(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic          run;
    logic          inflight;
    logic [1:0]    occ;
    logic [1:0]    pending;
    logic          m_valid;
    logic          pop;
    logic          r_enb;
    logic          last;
    logic [BW-1:0] beat_cnt;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && bus.m_ready;
    assign pending = occ + {1'b0, inflight};

    // A pop this cycle frees a slot, so ready feeds straight into the read decision.
    assign r_enb = run && enable && !bus.fifo_empty && ((pending < 2'd2) || pop);
    assign last  = m_valid && (beat_cnt == LAST_BEAT);

    assign bus.fifo_r_enb = r_enb;
    assign bus.m_valid    = m_valid;
    assign bus.m_last     = last;
    assign idle           = (occ == 2'd0) && !inflight && !r_enb;

    // Hold off reads on the reset-release edge; run comes up one clock later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // The FIFO returns data one clock after an accepted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= r_enb;
        end
    end

    // Beat position within the burst and completed-burst count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt  <= '0;
            pkt_count <= '0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
            if (last) begin
                pkt_count <= pkt_count + PKT_CW'(1);
            end
        end
    end

    stream_skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight),
        .push_data(bus.fifo_d_out),
        .pop      (pop),
        .head     (bus.m_data),
        .occ      (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: two readers (BURST_LEN 4 and 1), each fed by a small behavioural
// synchronous FIFO (depth 16, registered d_out), checked with immediate assertions.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;
    logic        enable1;
    logic [15:0] pkt4;
    logic [15:0] pkt1;
    logic        idle4;
    logic        idle1;

    fifo_stream_reader_if #(.WIDTH(32)) bus4 ();
    fifo_stream_reader_if #(.WIDTH(32)) bus1 ();

    fifo_stream_reader #(.WIDTH(32), .BURST_LEN(4), .PKT_CW(16)) u4 (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus4),
        .pkt_count(pkt4), .idle(idle4)
    );

    fifo_stream_reader #(.WIDTH(32), .BURST_LEN(1), .PKT_CW(16)) u1 (
        .clk(clk), .reset(reset), .enable(enable1), .bus(bus1),
        .pkt_count(pkt1), .idle(idle1)
    );

    // Behavioural FIFOs: index 0 feeds u4, index 1 feeds u1.
    fifo_word_t  fmem [2][16];
    logic [3:0]  fwp [2];
    logic [3:0]  frp [2];
    logic [4:0]  fcnt [2];
    fifo_word_t  fdout [2];
    logic        fwr [2];
    fifo_word_t  fwdata [2];
    logic        frd [2];

    assign frd[0] = bus4.fifo_r_enb;
    assign frd[1] = bus1.fifo_r_enb;
    assign bus4.fifo_empty = (fcnt[0] == 5'd0);
    assign bus1.fifo_empty = (fcnt[1] == 5'd0);
    assign bus4.fifo_d_out = fdout[0];
    assign bus1.fifo_d_out = fdout[1];

    always @(posedge clk or negedge reset) begin
        for (int f = 0; f < 2; f++) begin
            if (!reset) begin
                fwp[f]   <= '0;
                frp[f]   <= '0;
                fcnt[f]  <= '0;
                fdout[f] <= '0;
            end else begin
                if (fwr[f] && fcnt[f] != 5'd16) begin
                    fmem[f][fwp[f]] <= fwdata[f];
                    fwp[f] <= fwp[f] + 4'd1;
                end
                if (frd[f] && fcnt[f] != 5'd0) begin
                    fdout[f] <= fmem[f][frp[f]];
                    frp[f] <= frp[f] + 4'd1;
                end
                fcnt[f] <= fcnt[f] + 5'(fwr[f] && fcnt[f] != 5'd16)
                                   - 5'(frd[f] && fcnt[f] != 5'd0);
            end
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         w;
    bit         chk_inv = 1'b0;
    bit         stall_prev = 1'b0;
    fifo_word_t prev_d;
    logic       prev_l;

    fifo_word_t got_d [$];
    bit         got_l [$];
    int         got_c [$];
    int         renb_c [$];
    fifo_word_t got1_d [$];
    bit         got1_l [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        got_d.delete(); got_l.delete(); got_c.delete(); renb_c.delete();
        got1_d.delete(); got1_l.delete();
    endtask

    // Called at a negedge with inputs already set; samples, then advances one clock.
    task automatic tick();
        #1;
        if (bus4.m_valid && bus4.m_ready) begin
            got_d.push_back(bus4.m_data);
            got_l.push_back(bus4.m_last);
            got_c.push_back(cyc);
        end
        if (bus4.fifo_r_enb) renb_c.push_back(cyc);
        if (bus1.m_valid && bus1.m_ready) begin
            got1_d.push_back(bus1.m_data);
            got1_l.push_back(bus1.m_last);
        end
        if (chk_inv) begin
            check("occ_le_2", 64'(u4.occ > 2'd2), 64'd0);
            check("no_read_when_empty", 64'(bus4.fifo_r_enb && bus4.fifo_empty), 64'd0);
            if (stall_prev) begin
                check("stall_data_stable", bus4.m_data, prev_d);
                check("stall_last_stable", bus4.m_last, prev_l);
            end
        end
        stall_prev = bus4.m_valid && !bus4.m_ready;
        prev_d     = bus4.m_data;
        prev_l     = bus4.m_last;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_word(input int f, input fifo_word_t d);
        fwr[f] = 1'b1;
        fwdata[f] = d;
        tick();
        fwr[f] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; enable = 1'b0; enable1 = 1'b0;
        bus4.m_ready = 1'b0; bus1.m_ready = 1'b1;
        fwr[0] = 1'b0; fwr[1] = 1'b0; fwdata[0] = '0; fwdata[1] = '0;

        // Reset state
        @(negedge clk); #1;
        check("rst_m_valid", bus4.m_valid, 0);
        check("rst_m_data", bus4.m_data, 0);
        check("rst_m_last", bus4.m_last, 0);
        check("rst_r_enb", bus4.fifo_r_enb, 0);
        check("rst_pkt", pkt4, 0);
        check("rst_idle", idle4, 1);
        check("rst_pkt1", pkt1, 0);
        check("rst_m_valid1", bus1.m_valid, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: 8 words streamed with ready held high
        for (int i = 0; i < 8; i++) push_word(0, 32'h100 + i);
        check("t1_no_read_disabled", bus4.fifo_r_enb, 0);
        clear_logs();
        enable = 1'b1; bus4.m_ready = 1'b1;
        w = cyc;
        repeat (14) tick();
        check("t1_count", got_d.size(), 8);
        for (int i = 0; i < 8 && i < got_d.size(); i++) begin
            check("t1_data", got_d[i], 32'h100 + i);
            check("t1_last", got_l[i], (i % 4 == 3) ? 1 : 0);
            check("t1_cycle", got_c[i], w + 2 + i);
        end
        check("t1_pkt", pkt4, 2);
        check("t1_idle", idle4, 1);
        check("t1_valid_low", bus4.m_valid, 0);

        // 2: 10 words with ready pattern 1,0,0,1
        enable = 1'b0;
        for (int i = 0; i < 10; i++) push_word(0, 32'h200 + i);
        clear_logs();
        enable = 1'b1; chk_inv = 1'b1; stall_prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            bus4.m_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        chk_inv = 1'b0;
        check("t2_count", got_d.size(), 10);
        for (int i = 0; i < 10 && i < got_d.size(); i++) begin
            check("t2_data", got_d[i], 32'h200 + i);
            check("t2_last", got_l[i], (i == 3 || i == 7) ? 1 : 0);
        end
        check("t2_pkt", pkt4, 4);

        // 3: empty FIFO, then a single word
        bus4.m_ready = 1'b1;
        clear_logs();
        chk_inv = 1'b1; stall_prev = 1'b0;
        repeat (3) tick();
        check("t3_no_read_empty", renb_c.size(), 0);
        clear_logs();
        w = cyc;
        push_word(0, 32'hA5);
        repeat (6) tick();
        chk_inv = 1'b0;
        check("t3_reads", renb_c.size(), 1);
        check("t3_beats", got_d.size(), 1);
        if (renb_c.size() == 1 && got_d.size() == 1) begin
            check("t3_read_cycle", renb_c[0], w + 1);
            check("t3_data", got_d[0], 32'hA5);
            check("t3_latency", got_c[0], renb_c[0] + 2);
            check("t3_last", got_l[0], 0);
        end

        // 4: enable dropped in the cycle a read issues
        enable = 1'b0;
        for (int i = 0; i < 5; i++) push_word(0, 32'h300 + i);
        clear_logs();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (8) tick();
        check("t4_one_read", renb_c.size(), 1);
        check("t4_one_beat", got_d.size(), 1);
        if (got_d.size() == 1) begin
            check("t4_data", got_d[0], 32'h300);
            check("t4_last", got_l[0], 1);
        end
        check("t4_pkt", pkt4, 5);
        check("t4_idle", idle4, 1);
        clear_logs();
        enable = 1'b1;
        repeat (10) tick();
        check("t4_rest_count", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            check("t4_rest_data", got_d[i], 32'h301 + i);
            check("t4_rest_last", got_l[i], (i == 3) ? 1 : 0);
        end
        check("t4_rest_pkt", pkt4, 6);

        // 5: reset pulsed after two beats of a burst
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push_word(0, 32'h400 + i);
        clear_logs();
        enable = 1'b1; bus4.m_ready = 1'b1;
        for (int k = 0; k < 10 && got_d.size() < 2; k++) tick();
        check("t5_two_beats", got_d.size(), 2);
        if (got_d.size() == 2) check("t5_beat2", got_d[1], 32'h401);
        reset = 1'b0;
        #1;
        check("t5_valid", bus4.m_valid, 0);
        check("t5_pkt", pkt4, 0);
        check("t5_data", bus4.m_data, 0);
        check("t5_last", bus4.m_last, 0);
        check("t5_r_enb", bus4.fifo_r_enb, 0);
        check("t5_idle", idle4, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_logs();
        for (int i = 0; i < 4; i++) push_word(0, 32'h500 + i);
        repeat (8) tick();
        check("t5_post_count", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            check("t5_post_data", got_d[i], 32'h500 + i);
            check("t5_post_last", got_l[i], (i == 3) ? 1 : 0);
        end
        check("t5_post_pkt", pkt4, 1);

        // 6: BURST_LEN=1 reader
        for (int i = 0; i < 3; i++) push_word(1, 32'h600 + i);
        clear_logs();
        enable1 = 1'b1;
        repeat (8) tick();
        check("t6_count", got1_d.size(), 3);
        for (int i = 0; i < 3 && i < got1_d.size(); i++) begin
            check("t6_data", got1_d[i], 32'h600 + i);
            check("t6_last", got1_l[i], 1);
        end
        check("t6_pkt", pkt1, 3);
        check("t6_idle", idle1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
